// File: rtl/il_bus_pkg.sv
// Shared types and address decode for the interleaved scratchpad crossbar.
package il_bus_pkg;

   // Port index covers all banks plus the internal error responder (index NUM_SLAVE).
   localparam int unsigned PORT_IDX_W = 8;
   typedef logic [PORT_IDX_W-1:0] port_idx_t;

   typedef struct packed {
      logic        in_range;
      logic [31:0] bank;
      logic [63:0] local_addr;
   } decode_t;

   function automatic decode_t il_decode(
      input logic [63:0] addr,
      input logic [63:0] base,
      input logic [63:0] size,
      input int unsigned aw,
      input int unsigned g,
      input int unsigned b
   );
      decode_t     d;
      logic [63:0] aw_mask;
      logic [63:0] off;
      aw_mask      = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
      off          = (addr - base) & aw_mask;
      d.in_range   = (addr >= base) && (off < size);
      d.bank       = 32'((off >> g) & ((64'd1 << b) - 64'd1));
      d.local_addr = ((off >> (g + b)) << g) | (off & ((64'd1 << g) - 64'd1));
      return d;
   endfunction

endpackage

// File: rtl/il_route_fifo.sv
// Per-bank FIFO of master ids, recording who owns each outstanding bank response.
module il_route_fifo #(
   parameter int unsigned ID_W  = 2,
   parameter int unsigned DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  logic [ID_W-1:0] i_push_id,
   input  logic            i_pop,
   output logic            o_full,
   output logic            o_empty,
   output logic [ID_W-1:0] o_head
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [ID_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]   r_rd;
   logic [PW-1:0]   r_wr;
   logic [CW-1:0]   r_cnt;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
         if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_push_id;
   end

endmodule

// File: rtl/il_bus_xbar_rr.sv
// OBI crossbar: NUM_MASTER masters onto word-interleaved banks with round-robin,
// request locking, per-bank response routing and an error responder for stray addresses.
module il_bus_xbar_rr
   import il_bus_pkg::*;
#(
   parameter int unsigned           NUM_MASTER      = 4,
   parameter int unsigned           NUM_SLAVE       = 4,
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           ADDR_WIDTH      = 32,
   parameter int unsigned           GRANULE_BYTES   = 4,
   parameter logic [ADDR_WIDTH-1:0] IL_ADDR_OFFSET  = 'h00008000,
   parameter logic [ADDR_WIDTH-1:0] IL_ADDR_SIZE    = 'h00020000,
   parameter int unsigned           MAX_OUTSTANDING = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NUM_MASTER-1:0]              m_req_i,
   input  logic [NUM_MASTER-1:0]              m_we_i,
   input  logic [NUM_MASTER*DATA_WIDTH/8-1:0] m_be_i,
   input  logic [NUM_MASTER*ADDR_WIDTH-1:0]   m_addr_i,
   input  logic [NUM_MASTER*DATA_WIDTH-1:0]   m_wdata_i,
   output logic [NUM_MASTER-1:0]              m_gnt_o,
   output logic [NUM_MASTER-1:0]              m_rvalid_o,
   output logic [NUM_MASTER*DATA_WIDTH-1:0]   m_rdata_o,
   output logic [NUM_MASTER-1:0]              m_err_o,
   output logic [NUM_SLAVE-1:0]               s_req_o,
   output logic [NUM_SLAVE-1:0]               s_we_o,
   output logic [NUM_SLAVE*DATA_WIDTH/8-1:0]  s_be_o,
   output logic [NUM_SLAVE*ADDR_WIDTH-1:0]    s_addr_o,
   output logic [NUM_SLAVE*DATA_WIDTH-1:0]    s_wdata_o,
   input  logic [NUM_SLAVE-1:0]               s_gnt_i,
   input  logic [NUM_SLAVE-1:0]               s_rvalid_i,
   input  logic [NUM_SLAVE*DATA_WIDTH-1:0]    s_rdata_i
);
   localparam int unsigned G   = $clog2(GRANULE_BYTES);
   localparam int unsigned B   = $clog2(NUM_SLAVE);
   localparam int unsigned MW  = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
   localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned BW  = DATA_WIDTH / 8;
   localparam int unsigned NP  = NUM_SLAVE + 1;
   localparam port_idx_t   ERR = port_idx_t'(NUM_SLAVE);

   decode_t               w_dec     [NUM_MASTER];
   port_idx_t             w_tgt     [NUM_MASTER];
   logic [ADDR_WIDTH-1:0] w_local   [NUM_MASTER];
   logic [NUM_MASTER-1:0] w_elig;
   logic [CW-1:0]         r_cnt     [NUM_MASTER];
   port_idx_t             r_tgt     [NUM_MASTER];
   logic [MW-1:0]         r_rr      [NP];
   logic [NP-1:0]         r_lock_vld;
   logic [MW-1:0]         r_lock_id [NP];
   logic [MW-1:0]         w_idx;
   logic [NP-1:0]         w_win_vld;
   logic [MW-1:0]         w_win     [NP];
   logic [NP-1:0]         w_full;
   logic [NP-1:0]         w_sgnt;
   logic [NP-1:0]         w_preq;
   logic [NP-1:0]         w_pgnt;
   logic [NUM_SLAVE-1:0]  w_fifo_full;
   logic [NUM_SLAVE-1:0]  w_empty;
   logic [NUM_SLAVE-1:0]  w_pop;
   logic [MW-1:0]         w_head    [NUM_SLAVE];
   logic                  r_err_vld_p1;
   logic [MW-1:0]         r_err_id_p1;
   logic                  r_live;

   always_comb begin
      for (int m = 0; m < NUM_MASTER; m++) begin
         w_dec[m]   = il_decode(64'(m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH]), 64'(IL_ADDR_OFFSET),
                                64'(IL_ADDR_SIZE), ADDR_WIDTH, G, B);
         w_tgt[m]   = w_dec[m].in_range ? port_idx_t'(w_dec[m].bank) : ERR;
         w_local[m] = w_dec[m].local_addr[ADDR_WIDTH-1:0];
         // A master may only stack requests on the port it is already waiting on.
         w_elig[m]  = m_req_i[m] && (r_cnt[m] < CW'(MAX_OUTSTANDING)) &&
                      ((r_cnt[m] == '0) || (w_tgt[m] == r_tgt[m]));
      end
   end

   assign w_full = {1'b0, w_fifo_full};
   assign w_sgnt = {1'b1, s_gnt_i};

   always_comb begin
      w_idx = '0;
      for (int p = 0; p < NP; p++) begin
         w_win_vld[p] = 1'b0;
         w_win[p]     = '0;
         for (int k = NUM_MASTER - 1; k >= 0; k--) begin
            w_idx = MW'((32'(r_rr[p]) + 32'(k)) % NUM_MASTER);
            if (w_elig[w_idx] && (w_tgt[w_idx] == port_idx_t'(p))) begin
               w_win_vld[p] = 1'b1;
               w_win[p]     = w_idx;
            end
         end
         if (r_lock_vld[p]) begin
            w_win_vld[p] = m_req_i[r_lock_id[p]];
            w_win[p]     = r_lock_id[p];
         end
         w_preq[p] = w_win_vld[p] && !w_full[p] && rst_ni;
         w_pgnt[p] = w_preq[p] && w_sgnt[p];
      end
   end

   assign s_req_o = w_preq[NUM_SLAVE-1:0];

   always_comb begin
      s_we_o    = '0;
      s_be_o    = '0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      m_gnt_o   = '0;
      for (int b = 0; b < NUM_SLAVE; b++) begin
         if (w_preq[b]) begin
            s_we_o[b]                               = m_we_i[w_win[b]];
            s_be_o[b*BW +: BW]                      = m_be_i[32'(w_win[b])*BW +: BW];
            s_addr_o[b*ADDR_WIDTH +: ADDR_WIDTH]    = w_local[w_win[b]];
            s_wdata_o[b*DATA_WIDTH +: DATA_WIDTH]   = m_wdata_i[32'(w_win[b])*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (w_pgnt[p]) m_gnt_o[w_win[p]] = 1'b1;
      end
   end

   always_comb begin
      m_rvalid_o = '0;
      m_err_o    = '0;
      m_rdata_o  = '0;
      for (int b = 0; b < NUM_SLAVE; b++) begin
         if (w_pop[b]) begin
            m_rvalid_o[w_head[b]]                                  = 1'b1;
            m_rdata_o[32'(w_head[b])*DATA_WIDTH +: DATA_WIDTH]     = s_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (r_err_vld_p1 && rst_ni) begin
         m_rvalid_o[r_err_id_p1] = 1'b1;
         m_err_o[r_err_id_p1]    = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_live <= 1'b0;
         for (int m = 0; m < NUM_MASTER; m++) begin
            r_cnt[m] <= '0;
            r_tgt[m] <= '0;
         end
         for (int p = 0; p < NP; p++) begin
            r_rr[p]       <= '0;
            r_lock_vld[p] <= 1'b0;
            r_lock_id[p]  <= '0;
         end
      end else begin
         r_live <= 1'b1;
         for (int m = 0; m < NUM_MASTER; m++) begin
            r_cnt[m] <= r_cnt[m] + CW'(m_gnt_o[m]) - CW'(m_rvalid_o[m]);
            if (m_gnt_o[m]) r_tgt[m] <= w_tgt[m];
         end
         for (int p = 0; p < NP; p++) begin
            if (w_pgnt[p]) begin
               r_rr[p]       <= MW'((32'(w_win[p]) + 32'd1) % NUM_MASTER);
               r_lock_vld[p] <= 1'b0;
            end else if (w_preq[p]) begin
               r_lock_vld[p] <= 1'b1;
               r_lock_id[p]  <= w_win[p];
            end
         end
      end
   end

   // Error responder stage: answers one cycle after its grant.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_err_vld_p1 <= 1'b0;
      else         r_err_vld_p1 <= w_pgnt[NUM_SLAVE];
   end

   always_ff @(posedge clk_i) begin
      r_err_id_p1 <= w_win[NUM_SLAVE];
   end

   for (genvar b = 0; b < NUM_SLAVE; b++) begin : g_bank
      il_route_fifo #(
         .ID_W  (MW),
         .DEPTH (MAX_OUTSTANDING)
      ) u_route_fifo (
         .i_clk     (clk_i),
         .i_rst_n   (rst_ni),
         .i_push    (w_pgnt[b]),
         .i_push_id (w_win[b]),
         .i_pop     (w_pop[b]),
         .o_full    (w_fifo_full[b]),
         .o_empty   (w_empty[b]),
         .o_head    (w_head[b])
      );

      assign w_pop[b] = s_rvalid_i[b] && !w_empty[b] && rst_ni;

      a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni || !r_live)
                                        !(s_rvalid_i[b] && w_empty[b]));
   end

endmodule
